// File: rtl/uart_axi_pkg.sv
`default_nettype none
//==============================================================================
// Module  : uart_axi_pkg
// Purpose : Shared constants and types for the UART-driven AXI4-Lite master:
//           command opcodes, error reply bytes, AXI response codes and the
//           command FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
//==============================================================================
package uart_axi_pkg;

    localparam logic [7:0] OP_WRITE    = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ     = 8'h52;  // 'R'
    localparam logic [7:0] ERR_OPCODE  = 8'hEE;
    localparam logic [7:0] ERR_TIMEOUT = 8'hEF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_AXI_AW   = 3'd3,
        ST_AXI_B    = 3'd4,
        ST_AXI_AR   = 3'd5,
        ST_AXI_R    = 3'd6,
        ST_SEND     = 3'd7
    } state_t;

    // Response image, MSB-first: STATUS byte followed by four data bytes.
    function automatic logic [39:0] resp_image(input logic [1:0]  resp,
                                               input logic [31:0] data);
        return {6'b0, resp, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_axi_resp_ser.sv
`default_nettype none
//==============================================================================
// Module  : uart_axi_resp_ser
// Purpose : Response serialiser. Loads up to five bytes (MSB first) and feeds
//           them one at a time to uart_tx, pulsing done once the last byte
//           has been accepted by the transmitter.
// Ports   : clk, reset (async, active-high), load_i, bytes_i[39:0],
//           count_i[2:0], tx_busy_i, tx_data_o[7:0], tx_start_o, done_o
// Rev     : 1.0  initial release
//==============================================================================
module uart_axi_resp_ser (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [39:0] bytes_i,
    input  logic [2:0]  count_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    output logic        done_o
);
    logic [39:0] shreg_q;
    logic [2:0]  left_q;
    logic        active_q;
    logic        guard_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    // The guard cycle covers the gap before uart_tx raises busy, so the last
    // byte is known to be in flight when done fires.
    assign done_o     = active_q && (left_q == 3'd0) && !guard_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q    <= '0;
            left_q     <= '0;
            active_q   <= 1'b0;
            guard_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            guard_q    <= 1'b0;
            if (load_i) begin
                shreg_q  <= bytes_i;
                left_q   <= count_i;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (done_o) begin
                    active_q <= 1'b0;
                end else if (!guard_q && (left_q != 3'd0) && !tx_busy_i) begin
                    tx_data_q  <= shreg_q[39:32];
                    shreg_q    <= {shreg_q[31:0], 8'h00};
                    left_q     <= left_q - 3'd1;
                    tx_start_q <= 1'b1;
                    guard_q    <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
//==============================================================================
// Module  : uart_rx
// Purpose : 8N1 UART receiver. A received byte is held in data with valid
//           high until read is pulsed; a byte completing while valid is still
//           high overwrites data (overrun).
// Ports   : clk, resetn (async, active-low), rx (serial in),
//           data[7:0], valid (byte available), read (consume pulse)
// Rev     : 1.0  initial release
//==============================================================================
module uart_rx #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       read
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   state_q;
    logic        sync1_q, sync2_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shreg_q;
    logic [7:0]  data_q;
    logic        valid_q;

    assign data  = data_q;
    assign valid = valid_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            if (read) valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    baud_q <= '0;
                    if (!sync2_q) state_q <= RX_START;
                end
                RX_START: begin
                    // Re-check the line mid start bit to reject glitches.
                    if (baud_q == 16'(CPB / 2 - 1)) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (baud_q == 16'(CPB - 1)) begin
                        baud_q  <= '0;
                        shreg_q <= {sync2_q, shreg_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    if (baud_q == 16'(CPB - 1)) begin
                        state_q <= RX_IDLE;
                        if (sync2_q) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
//==============================================================================
// Module  : uart_tx
// Purpose : 8N1 UART transmitter. start is honoured only while busy is low;
//           busy rises the cycle after start and falls after the stop bit.
// Ports   : clk, resetn (async, active-low), data[7:0], start, tx, busy
// Rev     : 1.0  initial release
//==============================================================================
module uart_tx #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;

    logic [9:0]  shreg_q;
    logic [15:0] baud_q;
    logic [3:0]  bit_q;
    logic        busy_q;
    logic        tx_q;

    assign tx   = tx_q;
    assign busy = busy_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else if (!busy_q) begin
            if (start) begin
                shreg_q <= {1'b1, data, 1'b0};
                baud_q  <= '0;
                bit_q   <= '0;
                busy_q  <= 1'b1;
                tx_q    <= 1'b0;
            end
        end else if (baud_q == 16'(CPB - 1)) begin
            baud_q <= '0;
            if (bit_q == 4'd9) begin
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                bit_q <= bit_q + 4'd1;
                tx_q  <= shreg_q[4'(bit_q + 4'd1)];
            end
        end else begin
            baud_q <= baud_q + 16'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_axi_master.sv
`default_nettype none
//==============================================================================
// Module  : uart_axi_master
// Purpose : UART-command-driven AXI4-Lite initiator. Decodes serial frames
//           (W: 57 A3..A0 D3..D0, R: 52 A3..A0), issues one AXI4-Lite access
//           and replies with STATUS (+ R3..R0 for reads); 0xEE for a bad
//           opcode.
// Ports   : clk, reset (async, active-high); AXI4-Lite master AW/W/B/AR/R
//           channels (m_axi_*); uart_rx / uart_tx serial pins; busy.
// Options : UART_AXI_FRAME_TIMEOUT_EN - when defined, a partial frame idle for
//           TIMEOUT_CYCLES is dropped and 0xEF is replied.
// Rev     : 1.0  initial release
//==============================================================================
module uart_axi_master
    import uart_axi_pkg::*;
#(
    parameter int CLOCK_FREQ     = 100000000,
    parameter int BAUD_RATE      = 115200,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic                      uart_rx,
    output logic                      uart_tx,
    output logic                      busy
);
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        rx_read_q, rx_read_d;

    logic        ser_load;
    logic [39:0] ser_bytes;
    logic [2:0]  ser_count;
    logic        ser_done;
    logic        take;
    logic        timeout;

    assign resetn = ~reset;

    uart_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk(clk), .resetn(resetn), .rx(uart_rx),
        .data(rx_data), .valid(rx_valid), .read(rx_read_q)
    );

    uart_tx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk(clk), .resetn(resetn), .data(tx_data), .start(tx_start),
        .tx(uart_tx), .busy(tx_busy)
    );

    uart_axi_resp_ser u_ser (
        .clk(clk), .reset(reset), .load_i(ser_load), .bytes_i(ser_bytes),
        .count_i(ser_count), .tx_busy_i(tx_busy), .tx_data_o(tx_data),
        .tx_start_o(tx_start), .done_o(ser_done)
    );

    // rx_valid only clears the cycle after the read pulse is seen by uart_rx,
    // so a byte is never taken while the previous read is still in flight.
    assign take = rx_valid && !rx_read_q;

`ifdef UART_AXI_FRAME_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    logic        in_frame;

    assign in_frame = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign timeout  = in_frame && (timer_q == 32'(TIMEOUT_CYCLES));

    always_comb begin
        timer_d = '0;
        if (in_frame && !take) timer_d = timer_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        rx_read_d  = 1'b0;
        ser_load   = 1'b0;
        ser_bytes  = '0;
        ser_count  = '0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    rx_read_d = 1'b1;
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_write_d = (rx_data == OP_WRITE);
                        cnt_d      = 2'd0;
                        state_d    = ST_GET_ADDR;
                    end else begin
                        ser_load  = 1'b1;
                        ser_bytes = {ERR_OPCODE, 32'h0};
                        ser_count = 3'd1;
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (take) begin
                    rx_read_d = 1'b1;
                    addr_d    = {addr_q[23:0], rx_data};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = ST_GET_DATA;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = ST_AXI_AR;
                        end
                    end
                end else if (timeout) begin
                    ser_load  = 1'b1;
                    ser_bytes = {ERR_TIMEOUT, 32'h0};
                    ser_count = 3'd1;
                    state_d   = ST_SEND;
                end
            end
            ST_GET_DATA: begin
                if (take) begin
                    rx_read_d = 1'b1;
                    data_d    = {data_q[23:0], rx_data};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_AXI_AW;
                    end
                end else if (timeout) begin
                    ser_load  = 1'b1;
                    ser_bytes = {ERR_TIMEOUT, 32'h0};
                    ser_count = 3'd1;
                    state_d   = ST_SEND;
                end
            end
            ST_AXI_AW: begin
                // AW and W retire independently; B waits for both.
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)    state_d   = ST_AXI_B;
            end
            ST_AXI_B: begin
                if (m_axi_bvalid) begin
                    ser_load  = 1'b1;
                    ser_bytes = resp_image(m_axi_bresp, 32'h0);
                    ser_count = 3'd1;
                    state_d   = ST_SEND;
                end
            end
            ST_AXI_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_AXI_R;
                end
            end
            ST_AXI_R: begin
                if (m_axi_rvalid) begin
                    ser_load  = 1'b1;
                    ser_bytes = resp_image(m_axi_rresp, m_axi_rdata);
                    ser_count = 3'd5;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rx_read_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            rx_read_q  <= rx_read_d;
        end
    end

    assign m_axi_awaddr  = addr_q[AXI_ADDR_WIDTH-1:0];
    assign m_axi_araddr  = addr_q[AXI_ADDR_WIDTH-1:0];
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_bready  = (state_q == ST_AXI_B);
    assign m_axi_rready  = (state_q == ST_AXI_R);
    assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire
